// File: rtl/bz_deserializer.sv
// Router-to-Core deserializer: pops 11-bit flits from a show-ahead FIFO and reassembles
// header + three data flits into one Core word. Consecutive words may share a single header.
module bz_deserializer #(
  parameter int unsigned NPCcode  = 8,
  parameter int unsigned NPCdata  = 24,
  parameter int unsigned NPCroute = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [10:0]                          q,
  input  logic                                 empty,
  output logic                                 rdreq,
  output logic [NPCroute+NPCcode+NPCdata-1:0]  PC_out_channel_d,
  output logic                                 PC_out_channel_v,
  input  logic                                 PC_out_channel_a,
  output logic                                 err
);

  typedef enum logic [2:0] {StHdr, StD1, StD2, StD3, StOut} state_e;

  state_e                state_q, state_d;
  logic [NPCroute-1:0]   route_q, route_d;
  logic [29:0]           data_q, data_d;
  logic                  more_n_q, more_n_d;
  logic                  v_q, v_d;
  logic                  err_q, err_d;

  logic                  tail;
  logic [9:0]            payload;

  assign tail    = q[0];
  assign payload = q[10:1];

  // No pops while a finished word waits for the Core.
  assign rdreq = reset & ~empty & (state_q != StOut);

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    data_d   = data_q;
    more_n_d = more_n_q;
    err_d    = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (rdreq) begin
          if (tail) begin
            err_d = 1'b1;
          end else begin
            route_d = NPCroute'(payload);
            state_d = StD1;
          end
        end
      end
      StD1: begin
        if (rdreq) begin
          if (tail) begin
            err_d   = 1'b1;
            state_d = StHdr;
          end else begin
            data_d[29:20] = payload;
            state_d       = StD2;
          end
        end
      end
      StD2: begin
        if (rdreq) begin
          if (tail) begin
            err_d   = 1'b1;
            state_d = StHdr;
          end else begin
            data_d[19:10] = payload;
            state_d       = StD3;
          end
        end
      end
      StD3: begin
        if (rdreq) begin
          data_d[9:0] = payload;
          more_n_d    = tail;
          state_d     = StOut;
        end
      end
      StOut: begin
        // Route register is kept when the run continues with another word.
        if (PC_out_channel_a) begin
          state_d = more_n_q ? StHdr : StD1;
        end
      end
      default: state_d = StHdr;
    endcase
    v_d = (state_d == StOut);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StHdr;
      route_q  <= '0;
      data_q   <= '0;
      more_n_q <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      data_q   <= data_d;
      more_n_q <= more_n_d;
      v_q      <= v_d;
      err_q    <= err_d;
    end
  end

  assign PC_out_channel_d = {route_q, {(NPCcode + NPCdata - 30){1'b0}}, data_q};
  assign PC_out_channel_v = v_q;
  assign err              = err_q;

endmodule
